// File: rtl/rename_pkg.sv
// Shared rename/ROB definitions: register file sizes and index types.
package rename_pkg;

    localparam int unsigned ARCH_REGS = 32;
    localparam int unsigned PHYS_REGS = 64;
    localparam int unsigned PREG_W    = 6;
    localparam int unsigned AREG_W    = 5;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [AREG_W-1:0] areg_t;

    localparam logic [6:0] OPCODE_STORE = 7'b0100011;

endpackage

// File: rtl/free_list.sv
// Circular FIFO of free physical registers: one pop port, two ordered push ports.
module free_list #(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned INIT_COUNT = 32,
    parameter int unsigned INIT_BASE  = 32,
    parameter int unsigned PREG_W     = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pop,
    input  logic                         push_en0,
    input  logic [PREG_W-1:0]            push_reg0,
    input  logic                         push_en1,
    input  logic [PREG_W-1:0]            push_reg1,
    output logic [PREG_W-1:0]            head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);
    import rename_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PREG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, wr1_ptr;
    logic [CNT_W-1:0]  count_q, count_d, occ0, occ1;
    logic              wr0, wr1, drop0, drop1;

    // Pointer/count next state; room is judged after the pop because the popped
    // entry is read before the edge, so its slot may be rewritten at that edge.
    always_comb begin
        occ0    = count_q - CNT_W'(pop);
        wr0     = push_en0 && (occ0 < CNT_W'(DEPTH));
        drop0   = push_en0 && !wr0;
        occ1    = occ0 + CNT_W'(wr0);
        wr1     = push_en1 && (occ1 < CNT_W'(DEPTH));
        drop1   = push_en1 && !wr1;
        wr1_ptr = tail_q + PTR_W'(wr0);
        head_d  = head_q + PTR_W'(pop);
        tail_d  = wr1_ptr + PTR_W'(wr1);
        count_d = occ1 + CNT_W'(wr1);
    end

    // Storage and pointers; reset preloads INIT_BASE.. in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= (i < int'(INIT_COUNT)) ? PREG_W'(int'(INIT_BASE) + i) : '0;
            end
            head_q  <= '0;
            tail_q  <= PTR_W'(INIT_COUNT);
            count_q <= CNT_W'(INIT_COUNT);
        end else begin
            if (wr0) mem_q[tail_q] <= push_reg0;
            if (wr1) mem_q[wr1_ptr] <= push_reg1;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // A push into a full list is a retire-side protocol error; it is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(drop0 || drop1)) else $error("free_list: push into full list dropped");
        end
    end

    assign head_data = mem_q[head_q];
    assign count     = count_q;
    assign empty     = (count_q == '0);

endmodule

// File: rtl/register_rename.sv
// Rename stage: RAT lookup/update, free-list allocation and a one-cycle output register.
module register_rename #(
    parameter int unsigned ARCH_REGS = rename_pkg::ARCH_REGS,
    parameter int unsigned PHYS_REGS = rename_pkg::PHYS_REGS,
    parameter int unsigned PREG_W    = rename_pkg::PREG_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [$clog2(ARCH_REGS)-1:0]     rs1,
    input  logic [$clog2(ARCH_REGS)-1:0]     rs2,
    input  logic [$clog2(ARCH_REGS)-1:0]     rd,
    input  logic                             rd_wen,
    input  logic [31:0]                      in_pc,
    input  logic                             free_en0,
    input  logic                             free_en1,
    input  logic [PREG_W-1:0]                free_reg0,
    input  logic [PREG_W-1:0]                free_reg1,
    output logic                             out_valid,
    output logic [PREG_W-1:0]                ps1,
    output logic [PREG_W-1:0]                ps2,
    output logic [PREG_W-1:0]                dr,
    output logic [PREG_W-1:0]                old_dr,
    output logic [31:0]                      out_pc,
    output logic                             stall,
    output logic [$clog2(PHYS_REGS+1)-1:0]   free_count
);
    import rename_pkg::*;

    localparam int unsigned CNT_W = $clog2(PHYS_REGS + 1);

    logic [PREG_W-1:0] rat_q [ARCH_REGS];
    logic              accept, alloc, push_en0, push_en1, fl_empty;
    logic [PREG_W-1:0] head_data, dr_d, old_dr_d;
    logic [CNT_W-1:0]  fl_count;

    logic              out_valid_q;
    logic [PREG_W-1:0] ps1_q, ps2_q, dr_q, old_dr_q;
    logic [31:0]       out_pc_q;

    // Accept/allocate decode; x0 destinations and free of p0 are ignored.
    always_comb begin
        accept   = in_valid && !fl_empty;
        alloc    = accept && rd_wen && (rd != '0);
        dr_d     = alloc ? head_data : '0;
        old_dr_d = alloc ? rat_q[rd] : '0;
        push_en0 = free_en0 && (free_reg0 != '0);
        push_en1 = free_en1 && (free_reg1 != '0);
    end

    free_list #(
        .DEPTH      (PHYS_REGS),
        .INIT_COUNT (PHYS_REGS - ARCH_REGS),
        .INIT_BASE  (ARCH_REGS),
        .PREG_W     (PREG_W)
    ) u_free_list (
        .clk       (clk),
        .rst       (rst),
        .pop       (alloc),
        .push_en0  (push_en0),
        .push_reg0 (free_reg0),
        .push_en1  (push_en1),
        .push_reg1 (free_reg1),
        .head_data (head_data),
        .count     (fl_count),
        .empty     (fl_empty)
    );

    // RAT: identity at reset; the write lands with the output register, so no bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ARCH_REGS); i++) begin
                rat_q[i] <= PREG_W'(i);
            end
        end else if (alloc) begin
            rat_q[rd] <= head_data;
        end
    end

    // Output pipeline register; payload holds when nothing is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ps1_q       <= '0;
            ps2_q       <= '0;
            dr_q        <= '0;
            old_dr_q    <= '0;
            out_pc_q    <= '0;
        end else begin
            out_valid_q <= accept;
            if (accept) begin
                ps1_q    <= rat_q[rs1];
                ps2_q    <= rat_q[rs2];
                dr_q     <= dr_d;
                old_dr_q <= old_dr_d;
                out_pc_q <= in_pc;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign ps1        = ps1_q;
    assign ps2        = ps2_q;
    assign dr         = dr_q;
    assign old_dr     = old_dr_q;
    assign out_pc     = out_pc_q;
    assign stall      = fl_empty;
    assign free_count = fl_count;

endmodule

// File: tb/tb_register_rename.sv
// Bench for register_rename: directed scenarios plus randomized traffic against a queue model.
module tb_register_rename;

    logic        clk = 1'b0;
    logic        rst, in_valid, rd_wen, free_en0, free_en1;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] in_pc, out_pc;
    logic [5:0]  free_reg0, free_reg1, ps1, ps2, dr, old_dr;
    logic        out_valid, stall;
    logic [6:0]  free_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: RAT as an array, free list and retire order as queues.
    logic [5:0]  m_rat [32];
    logic [5:0]  m_fl  [$];
    logic [5:0]  m_rob [$];
    logic        e_valid;
    logic [5:0]  e_ps1, e_ps2, e_dr, e_old;
    logic [31:0] e_pc;

    always #5 clk = ~clk;

    register_rename dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .rd_wen     (rd_wen),
        .in_pc      (in_pc),
        .free_en0   (free_en0),
        .free_en1   (free_en1),
        .free_reg0  (free_reg0),
        .free_reg1  (free_reg1),
        .out_valid  (out_valid),
        .ps1        (ps1),
        .ps2        (ps2),
        .dr         (dr),
        .old_dr     (old_dr),
        .out_pc     (out_pc),
        .stall      (stall),
        .free_count (free_count)
    );

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rat[i] = 6'(i);
        m_fl.delete();
        for (int i = 32; i < 64; i++) m_fl.push_back(6'(i));
        m_rob.delete();
        e_valid = 1'b0;
    endtask

    task automatic idle_inputs();
        in_valid = 0; rs1 = 0; rs2 = 0; rd = 0; rd_wen = 0; in_pc = 0;
        free_en0 = 0; free_reg0 = 0; free_en1 = 0; free_reg1 = 0;
    endtask

    // Reset with live rename and free traffic on the inputs; reset must win.
    task automatic do_reset();
        rst = 1; in_valid = 1; rs1 = 3; rs2 = 4; rd = 9; rd_wen = 1; in_pc = 32'hdead_beef;
        free_en0 = 1; free_reg0 = 6'd7; free_en1 = 1; free_reg1 = 6'd8;
        @(posedge clk); #1;
        rst = 0;
        idle_inputs();
        model_reset();
    endtask

    // Drive one cycle, advance the model, sample 1 time unit after the edge.
    task automatic step(input logic iv, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] d, input logic w, input logic [31:0] pc,
                        input logic fe0, input logic [5:0] fr0,
                        input logic fe1, input logic [5:0] fr1);
        in_valid = iv; rs1 = a1; rs2 = a2; rd = d; rd_wen = w; in_pc = pc;
        free_en0 = fe0; free_reg0 = fr0; free_en1 = fe1; free_reg1 = fr1;
        e_valid = iv && (m_fl.size() != 0);
        if (e_valid) begin
            e_ps1 = m_rat[a1];
            e_ps2 = m_rat[a2];
            e_pc  = pc;
            if (w && d != 0) begin
                e_dr  = m_fl.pop_front();
                e_old = m_rat[d];
                m_rat[d] = e_dr;
                m_rob.push_back(e_old);
            end else begin
                e_dr  = 6'd0;
                e_old = 6'd0;
            end
        end
        if (fe0 && fr0 != 0) m_fl.push_back(fr0);
        if (fe1 && fr1 != 0) m_fl.push_back(fr1);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if ({ps1, ps2, dr, old_dr} !== 24'd0) begin failures++; $display("FAIL reset_regs got=%h exp=0", {ps1, ps2, dr, old_dr}); end
        checks++; if (out_pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        checks++; if (free_count !== 7'd32) begin failures++; $display("FAIL reset_count got=%0d exp=32", free_count); end
    endtask

    task automatic test_first_rename();
        step(1, 5'd1, 5'd2, 5'd5, 1, 32'h1000, 0, 0, 0, 0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%0b exp=1", out_valid); end
        checks++; if (ps1 !== 6'd1 || ps2 !== 6'd2) begin failures++; $display("FAIL first_src got=%0d/%0d exp=1/2", ps1, ps2); end
        checks++; if (dr !== 6'd32 || old_dr !== 6'd5) begin failures++; $display("FAIL first_dst got=%0d/%0d exp=32/5", dr, old_dr); end
        checks++; if (out_pc !== 32'h1000) begin failures++; $display("FAIL first_pc got=%h exp=1000", out_pc); end
        checks++; if (free_count !== 7'd31) begin failures++; $display("FAIL first_count got=%0d exp=31", free_count); end
    endtask

    task automatic test_back_to_back();
        step(1, 5'd5, 5'd3, 5'd5, 1, 32'h1004, 0, 0, 0, 0);
        checks++; if (ps1 !== 6'd32 || ps2 !== 6'd3) begin failures++; $display("FAIL b2b_src got=%0d/%0d exp=32/3", ps1, ps2); end
        checks++; if (dr !== 6'd33 || old_dr !== 6'd32) begin failures++; $display("FAIL b2b_dst got=%0d/%0d exp=33/32", dr, old_dr); end
        checks++; if (free_count !== 7'd30) begin failures++; $display("FAIL b2b_count got=%0d exp=30", free_count); end
    endtask

    task automatic test_no_dest();
        step(1, 5'd5, 5'd6, 5'd7, 0, 32'h1008, 0, 0, 0, 0);
        checks++; if (out_valid !== 1'b1 || dr !== 6'd0 || old_dr !== 6'd0) begin failures++; $display("FAIL store_dst got=%0b/%0d/%0d exp=1/0/0", out_valid, dr, old_dr); end
        checks++; if (ps1 !== 6'd33) begin failures++; $display("FAIL store_src got=%0d exp=33", ps1); end
        checks++; if (free_count !== 7'd30) begin failures++; $display("FAIL store_count got=%0d exp=30", free_count); end
        step(1, 5'd0, 5'd0, 5'd0, 1, 32'h100c, 0, 0, 0, 0);
        checks++; if (dr !== 6'd0 || old_dr !== 6'd0) begin failures++; $display("FAIL x0_dst got=%0d/%0d exp=0/0", dr, old_dr); end
        checks++; if (free_count !== 7'd30) begin failures++; $display("FAIL x0_count got=%0d exp=30", free_count); end
        step(1, 5'd0, 5'd0, 5'd4, 1, 32'h1010, 0, 0, 0, 0);
        checks++; if (ps1 !== 6'd0 || dr !== 6'd34) begin failures++; $display("FAIL x0_rat got=%0d/%0d exp=0/34", ps1, dr); end
    endtask

    task automatic test_drain_recover();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            step(1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'(1 + i % 31), 1,
                 32'(i), 0, 0, 0, 0);
            checks++; if (out_valid !== 1'b1 || dr !== 6'(32 + i)) begin failures++; $display("FAIL drain_alloc i=%0d got=%0b/%0d exp=1/%0d", i, out_valid, dr, 32 + i); end
        end
        checks++; if (stall !== 1'b1 || free_count !== 7'd0) begin failures++; $display("FAIL drain_empty got=%0b/%0d exp=1/0", stall, free_count); end
        for (int i = 0; i < 2; i++) begin
            step(1, 5'd1, 5'd2, 5'd3, 1, 32'h2000, 0, 0, 0, 0);
            checks++; if (out_valid !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL stall_hold got=%0b/%0b exp=0/1", out_valid, stall); end
        end
        step(1, 5'd1, 5'd2, 5'd3, 1, 32'h2004, 1, 6'd40, 0, 0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL recover_valid got=%0b exp=0", out_valid); end
        checks++; if (stall !== 1'b0 || free_count !== 7'd1) begin failures++; $display("FAIL recover_stall got=%0b/%0d exp=0/1", stall, free_count); end
        step(1, 5'd1, 5'd2, 5'd10, 1, 32'h2008, 0, 0, 0, 0);
        checks++; if (out_valid !== 1'b1 || dr !== 6'd40) begin failures++; $display("FAIL recover_dr got=%0b/%0d exp=1/40", out_valid, dr); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 22; i++) step(1, 5'd0, 5'd0, 5'(1 + i % 15), 1, 32'(i), 0, 0, 0, 0);
        checks++; if (free_count !== 7'd10) begin failures++; $display("FAIL simul_pre got=%0d exp=10", free_count); end
        step(1, 5'd0, 5'd0, 5'd3, 1, 32'h3000, 1, 6'd17, 1, 6'd0);
        checks++; if (dr !== 6'd54) begin failures++; $display("FAIL simul_dr got=%0d exp=54", dr); end
        checks++; if (free_count !== 7'd10) begin failures++; $display("FAIL simul_count got=%0d exp=10", free_count); end
        for (int i = 0; i < 10; i++) begin
            step(1, 5'd0, 5'd0, 5'd20, 1, 32'h3100, 0, 0, 0, 0);
            checks++; if (dr !== e_dr) begin failures++; $display("FAIL simul_order i=%0d got=%0d exp=%0d", i, dr, e_dr); end
        end
        checks++; if (dr !== 6'd17) begin failures++; $display("FAIL simul_last got=%0d exp=17", dr); end
    endtask

    // Phased random traffic: allocation-heavy phases drain the list, free-heavy refill it.
    task automatic test_random_wrap();
        logic       iv, w, fe0, fe1;
        logic [5:0] fr0, fr1;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            iv = ($urandom_range(0, 3) != 0);
            w  = ($urandom_range(0, 4) != 0);
            fe0 = 0; fr0 = 0; fe1 = 0; fr1 = 0;
            if ((n % 160) < 80) begin
                if (m_rob.size() != 0 && $urandom_range(0, 7) == 0) begin fe0 = 1; fr0 = m_rob.pop_front(); end
            end else begin
                if (m_rob.size() != 0 && $urandom_range(0, 3) != 0) begin fe0 = 1; fr0 = m_rob.pop_front(); end
                if (m_rob.size() != 0 && $urandom_range(0, 1) != 0) begin fe1 = 1; fr1 = m_rob.pop_front(); end
                else if ($urandom_range(0, 9) == 0) begin fe1 = 1; fr1 = 6'd0; end
            end
            step(iv, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 w, $urandom, fe0, fr0, fe1, fr1);
            checks++; if (out_valid !== e_valid) begin failures++; $display("FAIL rand_valid n=%0d got=%0b exp=%0b", n, out_valid, e_valid); end
            if (e_valid) begin
                checks++; if ({ps1, ps2, dr, old_dr} !== {e_ps1, e_ps2, e_dr, e_old}) begin failures++; $display("FAIL rand_regs n=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", n, ps1, ps2, dr, old_dr, e_ps1, e_ps2, e_dr, e_old); end
                checks++; if (out_pc !== e_pc) begin failures++; $display("FAIL rand_pc n=%0d got=%h exp=%h", n, out_pc, e_pc); end
            end
            checks++; if (free_count !== 7'(m_fl.size())) begin failures++; $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, free_count, m_fl.size()); end
            checks++; if (stall !== (m_fl.size() == 0)) begin failures++; $display("FAIL rand_stall n=%0d got=%0b exp=%0b", n, stall, m_fl.size() == 0); end
        end
    endtask

    task automatic test_reset_mid();
        for (int n = 0; n < 20; n++) step(1, 5'd1, 5'd2, 5'(1 + n), 1, 32'(n), 0, 0, 0, 0);
        do_reset();
        checks++; if (out_valid !== 1'b0 || {ps1, ps2, dr, old_dr} !== 24'd0) begin failures++; $display("FAIL mid_rst_out got=%0b/%h exp=0/0", out_valid, {ps1, ps2, dr, old_dr}); end
        checks++; if (free_count !== 7'd32 || stall !== 1'b0) begin failures++; $display("FAIL mid_rst_count got=%0d/%0b exp=32/0", free_count, stall); end
        for (int i = 0; i < 32; i++) begin
            step(1, 5'(i), 5'(31 - i), 5'd0, 0, 32'h4000, 0, 0, 0, 0);
            checks++; if (ps1 !== 6'(i) || ps2 !== 6'(31 - i)) begin failures++; $display("FAIL mid_rst_rat i=%0d got=%0d/%0d exp=%0d/%0d", i, ps1, ps2, i, 31 - i); end
        end
        step(1, 5'd0, 5'd0, 5'd5, 1, 32'h4004, 0, 0, 0, 0);
        checks++; if (dr !== 6'd32 || old_dr !== 6'd5) begin failures++; $display("FAIL mid_rst_alloc got=%0d/%0d exp=32/5", dr, old_dr); end
    endtask

    initial begin
        test_reset();
        test_first_rename();
        test_back_to_back();
        test_no_dest();
        test_drain_recover();
        test_simultaneous();
        test_random_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_rename.md
# register_rename

Front-end rename stage. It sits between decode and the reorder buffer, mapping 5-bit architectural registers onto 6-bit physical registers through a register alias table (RAT) and a circular free list. Each cycle it renames one instruction and produces `dr`/`old_dr` for ROB allocation. Each cycle it also reclaims up to two physical registers freed by ROB retirement (`old_dr` of retired instructions).

## Interface
Parameters:
- `ARCH_REGS`, default 32: number of architectural registers.
- `PHYS_REGS`, default 64: number of physical registers, and the free-list depth.
- `PREG_W`, default 6: physical register index width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: decoded instruction present.
- `rs1`, `rs2` in 5: architectural sources.
- `rd` in 5: architectural destination.
- `rd_wen` in 1: instruction writes `rd` (0 for stores and branches).
- `in_pc` in 32: instruction PC.
- `free_en0`, `free_en1` in 1: retire-side free strobes.
- `free_reg0`, `free_reg1` in 6: physical registers to return to the free list.
- `out_valid` out 1: renamed instruction valid, registered.
- `ps1`, `ps2` out 6: physical sources.
- `dr` out 6: newly allocated physical destination.
- `old_dr` out 6: previous mapping of `rd`; the ROB frees it at retire.
- `out_pc` out 32: PC passed through.
- `stall` out 1: free list empty; upstream must hold its instruction.
- `free_count` out 7: number of entries in the free list (0..64).

## Operation
- **Reset:**
  - RAT[i] = i for i = 0..31.
  - Free list holds 32..63 in order; head = 0, tail = 32, count = 32.
  - Physical register 0 is permanently bound to x0.
- **Accept:** an instruction is accepted when `in_valid && !stall`.
- **Rename, for an accepted instruction:**
  - `ps1` = RAT[rs1] and `ps2` = RAT[rs2], read from the pre-edge RAT.
  - If `rd_wen && rd != 0`: `dr` = free list[head], `old_dr` = RAT[rd], RAT[rd] <= `dr`, and one entry is popped.
  - Otherwise `dr` = 0, `old_dr` = 0, and nothing is popped.
- **Sources need no bypass.** The RAT write from instruction N lands at the same edge that registers N, so N+1 reads the updated mapping.
- **Free:**
  - Each asserted `free_enK` with a nonzero `free_regK` pushes that register at the tail.
  - Port 0 pushes before port 1.
  - Freeing register 0 is ignored.
- **Count update:** count_next = count − pop + pushes.
- **Wrap-around:** head and tail are 6-bit pointers that wrap 63 → 0.
- **Overflow:** a push when count = 64 is a protocol error. It is dropped, and an assertion fires in simulation.
- **Freed registers are not reusable in the same cycle.** A register freed in cycle T is allocatable no earlier than T+1, because the pop reads head before the pushes land.
- **Stall:**
  - `stall` = (count == 0), driven from the registered count.
  - While stalled, `out_valid` goes to 0 on the next edge and no RAT or free-list state changes from the rename side.
  - Frees still proceed while stalled.

## Timing
- Rename latency is 1 cycle: an instruction accepted at edge T appears on `out_*` after T.
- `out_valid` is 0 in every cycle following a non-accepted cycle.
- `stall` deasserts in the cycle after the first push into an empty list.
- **Reset values:**
  - `out_valid`, `ps1`, `ps2`, `dr`, `old_dr`, `out_pc` = 0.
  - `stall` = 0.
  - `free_count` = 32.
- **Reset mid-operation:** `rst` dominates a simultaneous rename or free. All in-flight mappings are discarded and the reset state is restored at that edge.

## Structure
- **Shared package `rename_pkg`:**
  - `ARCH_REGS`, `PHYS_REGS`, `PREG_W`.
  - `preg_t` (6-bit) and `areg_t` (5-bit) typedefs.
  - `OPCODE_STORE` = 7'b0100011.
  - The package is also used by the ROB.
- **Sub-module `free_list`:**
  - 64×6 circular FIFO with 1 pop port and 2 push ports.
  - Outputs: count, empty, and head data.
- **Top level:** the RAT, `free_list`, and the output pipeline register.

## Test plan
- **Reset, then first rename:**
  - Stimulus: `rd`=5, `rs1`=1, `rs2`=2, `rd_wen`=1.
  - Response: next cycle `out_valid`=1, `ps1`=1, `ps2`=2, `dr`=32, `old_dr`=5, `free_count`=31.
- **Back-to-back dependency:**
  - Stimulus: second instruction `rd`=5, `rs1`=5.
  - Response: `ps1`=32, `dr`=33, `old_dr`=32, `free_count`=30.
- **No-destination instructions:**
  - Stimulus: a store (`rd_wen`=0), then `rd`=0 with `rd_wen`=1.
  - Response: `dr`=0, `old_dr`=0 for both; `free_count` unchanged; RAT[0] stays 0.
- **Drain and recover:**
  - Stimulus: 32 allocating instructions.
  - Response: `stall`=1 once count hits 0, and `out_valid`=0 while `in_valid` is held.
  - Stimulus: `free_en0` with `free_reg0`=40.
  - Response: `stall`=0 the next cycle; the next rename gets `dr`=40.
- **Simultaneous events:**
  - Stimulus: count=10, one pop plus two frees (17, 0).
  - Response: count=10 (only 17 is pushed); 17 is not allocated in the same cycle.
- **Wrap-around and reset:**
  - Stimulus: more than 64 alloc/free cycles so that the pointers wrap.
  - Response: FIFO order is preserved across 63→0.
  - Stimulus: assert `rst` mid-stream.
  - Response: identity RAT and `free_count`=32 on the next cycle.
